// File: rtl/rv32i_uart_pkg.sv
// Shared register offsets, STATUS bit positions and FSM encodings for the rv32i MMIO UART.
package rv32i_uart_pkg;

   localparam logic [1:0] UART_TXDATA = 2'd0;
   localparam logic [1:0] UART_STATUS = 2'd1;
   localparam logic [1:0] UART_CTRL   = 2'd2;
   localparam logic [1:0] UART_RXDATA = 2'd3;

   localparam int ST_FULL  = 0;
   localparam int ST_EMPTY = 1;
   localparam int ST_BUSY  = 2;
   localparam int ST_HALF  = 3;
   localparam int ST_OVF   = 4;
   localparam int ST_RXV   = 5;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

endpackage

// File: rtl/rv32i_uart_fifo.sv
// Synchronous circular FIFO with extra-msb pointers; a push while full is dropped
// even if a pop happens in the same cycle.
module rv32i_uart_fifo
   import rv32i_uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_in,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             half_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] HALF = (AW+1)'(DEPTH / 2);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q, rptr_q, count_s;
   logic             push_ok_s, pop_ok_s;

   assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign empty_o   = (wptr_q == rptr_q);
   assign count_s   = wptr_q - rptr_q;
   assign half_o    = (count_s >= HALF);
   assign push_ok_s = push_i & ~full_o;
   assign pop_ok_s  = pop_i & ~empty_o;
   assign rdata_o   = mem_q[rptr_q[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (!rst_in) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push_ok_s) wptr_q <= wptr_q + (AW+1)'(1);
         if (pop_ok_s)  rptr_q <= rptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok_s) mem_q[wptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/rv32i_uart_mmio.sv
// Memory-mapped 8N1 UART (TX FIFO, baud divisor, status, TX-empty irq) on the rv32i data port.
// Define UART_MMIO_RX_EN to add the rx_i receiver, the RXDATA register and the RX interrupt.
module rv32i_uart_mmio
   import rv32i_uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
   parameter logic [15:0] DIV_RESET  = 16'd433,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic        clk_i,
   input  logic        rst_in,
`ifdef UART_MMIO_RX_EN
   input  logic        rx_i,
`endif
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   output logic        sel_o,
   output logic [31:0] rdata_o,
   output logic        tx_o,
   output logic        irq_o
);
   tx_state_e   state_q, state_d;
   logic [15:0] div_q, divl_q, divl_d, cnt_q, cnt_d;
   logic [7:0]  shift_q, shift_d, fifo_rdata_s;
   logic [2:0]  bit_q, bit_d;
   logic        ie_q, ovf_q, ovf_d, tx_q, tx_d, irq_q;
   logic        fifo_full_s, fifo_empty_s, fifo_half_s, pop_s, busy_s;
   logic        wr_s, push_s, ovf_clr_s, ctrl_wr_s;
   logic        rx_valid_s, rx_ovf_s;
   logic [31:0] rx_word_s, status_s;
   logic [1:0]  off_s;
   logic        unused_s;

   assign sel_o     = (addr_i[31:4] == BASE_ADDR[31:4]);
   assign off_s     = addr_i[3:2];
   assign wr_s      = we_i & sel_o;
   assign push_s    = wr_s & be_i[0] & (off_s == UART_TXDATA);
   assign ovf_clr_s = wr_s & be_i[0] & (off_s == UART_STATUS) & wdata_i[ST_OVF];
   assign ctrl_wr_s = wr_s & (off_s == UART_CTRL);
   assign busy_s    = (state_q != TX_IDLE);
   assign tx_o      = tx_q;
   assign irq_o     = irq_q;
   assign unused_s  = ^{addr_i[1:0], wdata_i[31:17], be_i[3]};

   rv32i_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk_i   (clk_i),
      .rst_in  (rst_in),
      .push_i  (push_s),
      .wdata_i (wdata_i[7:0]),
      .pop_i   (pop_s),
      .rdata_o (fifo_rdata_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s),
      .half_o  (fifo_half_s)
   );

   always_comb begin
      status_s           = 32'd0;
      status_s[ST_FULL]  = fifo_full_s;
      status_s[ST_EMPTY] = fifo_empty_s;
      status_s[ST_BUSY]  = busy_s;
      status_s[ST_HALF]  = fifo_half_s;
      status_s[ST_OVF]   = ovf_q;
      status_s[ST_RXV]   = rx_valid_s;
      rdata_o            = 32'd0;
      if (sel_o) begin
         case (off_s)
            UART_STATUS: rdata_o = status_s;
            UART_CTRL:   rdata_o = {15'd0, ie_q, div_q};
            UART_RXDATA: rdata_o = rx_word_s;
            default:     rdata_o = 32'd0;
         endcase
      end
   end

   // Overflow: a set in the same cycle as a clear wins so no drop is lost.
   always_comb begin
      ovf_d = ovf_q;
      if (ovf_clr_s) ovf_d = 1'b0;
      if ((push_s & fifo_full_s) | rx_ovf_s) ovf_d = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 16'd1;
      bit_d   = bit_q;
      shift_d = shift_q;
      divl_d  = divl_q;
      pop_s   = 1'b0;
      case (state_q)
         TX_IDLE: begin
            cnt_d = 16'd0;
            if (!fifo_empty_s) begin
               pop_s   = 1'b1;
               shift_d = fifo_rdata_s;
               divl_d  = div_q;
               state_d = TX_START;
            end
         end
         TX_START: if (cnt_q == divl_q) begin
            cnt_d   = 16'd0;
            bit_d   = 3'd0;
            state_d = TX_DATA;
         end
         TX_DATA: if (cnt_q == divl_q) begin
            cnt_d   = 16'd0;
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = TX_STOP;
         end
         TX_STOP: if (cnt_q == divl_q) begin
            cnt_d   = 16'd0;
            state_d = TX_IDLE;
         end
         default: state_d = TX_IDLE;
      endcase
      // Line level follows the next state so tx_q changes on the same edge as the FSM.
      case (state_d)
         TX_START: tx_d = 1'b0;
         TX_DATA:  tx_d = shift_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_in) begin
         state_q <= TX_IDLE;
         cnt_q   <= 16'd0;
         bit_q   <= 3'd0;
         shift_q <= 8'd0;
         divl_q  <= DIV_RESET;
         div_q   <= DIV_RESET;
         ie_q    <= 1'b0;
         ovf_q   <= 1'b0;
         tx_q    <= 1'b1;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         divl_q  <= divl_d;
         ovf_q   <= ovf_d;
         tx_q    <= tx_d;
         irq_q   <= (ie_q & fifo_empty_s & ~busy_s) | (ie_q & rx_valid_s);
         if (ctrl_wr_s & be_i[0]) div_q[7:0]  <= wdata_i[7:0];
         if (ctrl_wr_s & be_i[1]) div_q[15:8] <= wdata_i[15:8];
         if (ctrl_wr_s & be_i[2]) ie_q        <= wdata_i[16];
      end
   end

`ifdef UART_MMIO_RX_EN
   rx_state_e   rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;
   logic [16:0] rx_half_s;
   logic [7:0]  rx_shift_q, rx_shift_d, rx_buf_q, rx_buf_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_valid_q, rx_valid_d, rx_clr_s, rx_ovf_d;

   assign rx_half_s  = ({1'b0, div_q} + 17'd1) >> 1;
   assign rx_clr_s   = wr_s & (off_s == UART_RXDATA);
   assign rx_valid_s = rx_valid_q;
   assign rx_ovf_s   = rx_ovf_d;
   assign rx_word_s  = {rx_valid_q, 23'd0, rx_buf_q};

   // Receiver samples mid-bit using the live divisor; bad stop bits drop the frame.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q + 16'd1;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_buf_d   = rx_buf_q;
      rx_valid_d = rx_valid_q & ~rx_clr_s;
      rx_ovf_d   = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = 16'd0;
            if (rx_prev_q & ~rx_s2_q) rx_state_d = RX_START;
         end
         RX_START: if ({1'b0, rx_cnt_q} == rx_half_s) begin
            rx_cnt_d   = 16'd0;
            rx_bit_d   = 3'd0;
            rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (rx_cnt_q == div_q) begin
            rx_cnt_d   = 16'd0;
            rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
         end
         RX_STOP: if (rx_cnt_q == div_q) begin
            rx_state_d = RX_IDLE;
            if (rx_s2_q && rx_valid_q) begin
               rx_ovf_d = 1'b1;
            end else if (rx_s2_q) begin
               rx_buf_d   = rx_shift_q;
               rx_valid_d = 1'b1;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_in) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= 16'd0;
         rx_bit_q   <= 3'd0;
         rx_shift_q <= 8'd0;
         rx_buf_q   <= 8'd0;
         rx_valid_q <= 1'b0;
      end else begin
         rx_s1_q    <= rx_i;
         rx_s2_q    <= rx_s1_q;
         rx_prev_q  <= rx_s2_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_buf_q   <= rx_buf_d;
         rx_valid_q <= rx_valid_d;
      end
   end
`else
   assign rx_valid_s = 1'b0;
   assign rx_ovf_s   = 1'b0;
   assign rx_word_s  = 32'd0;
`endif

endmodule

// File: tb/tb_rv32i_uart_mmio.sv
// Directed self-checking bench for rv32i_uart_mmio; exercises the RX path when UART_MMIO_RX_EN is defined.
module tb_rv32i_uart_mmio;
   localparam logic [31:0] BASE = 32'h8000_0000;

   logic        clk = 1'b0, rst_n = 1'b0, we = 1'b0;
   logic [31:0] addr = 32'd0, wdata = 32'd0;
   logic [3:0]  be = 4'd0;
   logic        sel, tx, irq;
   logic [31:0] rdata, rd;
   logic [63:0] vec, expv;
   logic [109:0] hist;
   int          n_tests = 0, n_fail = 0, n_wait, n_low;
`ifdef UART_MMIO_RX_EN
   logic        rx = 1'b1;
`endif

   always #5 clk = ~clk;

   rv32i_uart_mmio dut (
      .clk_i   (clk),
      .rst_in  (rst_n),
`ifdef UART_MMIO_RX_EN
      .rx_i    (rx),
`endif
      .addr_i  (addr),
      .wdata_i (wdata),
      .we_i    (we),
      .be_i    (be),
      .sel_o   (sel),
      .rdata_o (rdata),
      .tx_o    (tx),
      .irq_o   (irq)
   );

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Drives one store cycle; assumes the caller is just after a falling edge.
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      addr  = a;
      wdata = d;
      be    = b;
      we    = 1'b1;
      @(negedge clk);
      we    = 1'b0;
      be    = 4'd0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = rdata;
   endtask

   function automatic logic [10:0] frame_bits(input logic [7:0] b);
      return {1'b1, 1'b1, b, 1'b0};
   endfunction

`ifdef UART_MMIO_RX_EN
   task automatic send_rx(input logic [7:0] b);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = f[i];
         repeat (4) @(negedge clk);
      end
      repeat (8) @(negedge clk);
   endtask
`endif

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check_eq("rst_tx", 64'(tx), 64'(1'b1));
      check_eq("rst_irq", 64'(irq), 64'(1'b0));
      bus_read(BASE + 32'h4, rd);  check_eq("rst_status", 64'(rd), 64'h2);
      bus_read(BASE + 32'h8, rd);  check_eq("rst_ctrl", 64'(rd), 64'd433);
      bus_read(BASE + 32'hC, rd);  check_eq("rxdata_idle", 64'(rd), 64'h0);
      bus_read(32'h9000_0004, rd); check_eq("unsel_read", 64'({sel, rd}), 64'h0);
      bus_read(BASE, rd);          check_eq("sel_base", 64'(sel), 64'(1'b1));

      // Stores outside the window or without be_i[0] must not push
      bus_write(32'h9000_0000, 32'h11, 4'hF);
      bus_write(BASE, 32'h22, 4'b1110);
      bus_read(BASE + 32'h4, rd);  check_eq("ignored_push", 64'(rd), 64'h2);

      // DIV=3, single 0x55 frame
      bus_write(BASE + 32'h8, 32'h0000_0003, 4'hF);
      bus_read(BASE + 32'h8, rd);  check_eq("ctrl_div3", 64'(rd), 64'h3);
      bus_write(BASE, 32'h55, 4'h1);
      check_eq("tx_before_start", 64'(tx), 64'(1'b1));
      vec  = 64'd0;
      expv = 64'd0;
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         vec[j] = tx;
         if (j / 4 == 0)      expv[j] = 1'b0;
         else if (j / 4 == 9) expv[j] = 1'b1;
         else                 expv[j] = ((8'h55 >> (j / 4 - 1)) & 8'h1) != 8'h0;
         if (j == 20) begin
            bus_read(BASE + 32'h4, rd); check_eq("status_busy", 64'(rd), 64'h6);
         end
      end
      check_eq("frame_55", vec, expv);
      @(negedge clk);
      bus_read(BASE + 32'h4, rd);  check_eq("status_after_55", 64'(rd), 64'h2);

      // DIV=0, fill the FIFO back-to-back, overflow on the push that finds it full
      bus_write(BASE + 32'h8, 32'h0, 4'b0011);
      bus_read(BASE + 32'h8, rd);  check_eq("ctrl_div0", 64'(rd), 64'h0);
      fork
         begin
            for (int k = 0; k < 9; k++) bus_write(BASE, 32'(k), 4'h1);
            bus_read(BASE + 32'h4, rd); check_eq("status_full_no_ovf", 64'(rd), 64'h0D);
            bus_write(BASE, 32'h9, 4'h1);
            bus_read(BASE + 32'h4, rd); check_eq("status_ovf_set", 64'(rd), 64'h1D);
            bus_write(BASE + 32'h4, 32'h10, 4'h1);
            bus_read(BASE + 32'h4, rd); check_eq("status_ovf_clr", 64'(rd), 64'h0D);
         end
         begin
            repeat (2) @(negedge clk);
            for (int j = 0; j < 110; j++) begin
               hist[j] = tx;
               @(negedge clk);
            end
         end
      join
      for (int k = 0; k < 10; k++) begin
         vec  = 64'd0;
         for (int j = 0; j < 11; j++) vec[j] = hist[11*k + j];
         expv = (k < 9) ? 64'(frame_bits(8'(k))) : 64'h7FF;
         check_eq($sformatf("burst_frame%0d", k), vec, expv);
      end
      bus_read(BASE + 32'h4, rd);  check_eq("status_drained", 64'(rd), 64'h2);

      // IE only via be_i[2]; irq after the last STOP
      bus_write(BASE + 32'h8, 32'h0001_0000, 4'b0100);
      bus_read(BASE + 32'h8, rd);  check_eq("ctrl_ie_only", 64'(rd), 64'h0001_0000);
      bus_write(BASE, 32'hC3, 4'h1);
      @(negedge clk);
      check_eq("irq_low_busy", 64'(irq), 64'(1'b0));
      n_wait = 0;
      while (irq !== 1'b1 && n_wait < 50) begin
         @(negedge clk);
         n_wait++;
      end
      check_eq("irq_rise_delay", 64'(n_wait), 64'd11);
      bus_read(BASE + 32'h4, rd);  check_eq("status_at_irq", 64'(rd), 64'h2);

      // Reset in the middle of the data bits of 0xA5
      bus_write(BASE + 32'h8, 32'h0000_0003, 4'b0111);
      bus_write(BASE, 32'hA5, 4'h1);
      bus_write(BASE, 32'h5A, 4'h1);
      repeat (9) @(negedge clk);
      check_eq("tx_mid_data", 64'(tx), 64'(1'b0));
      rst_n = 1'b0;
      @(negedge clk);
      check_eq("tx_after_rst", 64'(tx), 64'(1'b1));
      check_eq("irq_after_rst", 64'(irq), 64'(1'b0));
      bus_read(BASE + 32'h4, rd);  check_eq("status_after_rst", 64'(rd), 64'h2);
      bus_read(BASE + 32'h8, rd);  check_eq("ctrl_after_rst", 64'(rd), 64'd433);
      @(negedge clk);
      rst_n = 1'b1;
      n_low = 0;
      for (int j = 0; j < 60; j++) begin
         @(negedge clk);
         if (tx !== 1'b1) n_low++;
      end
      check_eq("no_resumed_frame", 64'(n_low), 64'd0);

`ifdef UART_MMIO_RX_EN
      bus_write(BASE + 32'h8, 32'h0000_0003, 4'hF);
      send_rx(8'h3C);
      bus_read(BASE + 32'hC, rd);  check_eq("rxdata_first", 64'(rd), 64'h8000_003C);
      bus_read(BASE + 32'h4, rd);  check_eq("status_rxv", 64'(rd), 64'h22);
      send_rx(8'h3C);
      bus_read(BASE + 32'h4, rd);  check_eq("status_rx_ovf", 64'(rd), 64'h32);
      bus_write(BASE + 32'hC, 32'h0, 4'h0);
      bus_read(BASE + 32'hC, rd);  check_eq("rxdata_cleared", 64'(rd), 64'h0000_003C);
      bus_read(BASE + 32'h4, rd);  check_eq("status_rxv_clr", 64'(rd), 64'h12);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
